// File: rtl/ysyx_22040750_ifu_pkg.sv
// ============================================================================
// Module      : ysyx_22040750_ifu_pkg
// Description : Shared IFU definitions: state codes, reset PC, widths, entry type.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_22040750_ifu_pkg;

  localparam int unsigned c_XLEN = 32;
  localparam int unsigned c_ILEN = 32;

  localparam logic [c_XLEN-1:0] c_RESET_PC = 32'h8000_0000;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;

  typedef struct packed {
    logic [c_XLEN-1:0] pc;
    logic [c_ILEN-1:0] inst;
  } fetch_entry_t;

  // Sequential successor; wraps modulo 2^32, low bits untouched.
  function automatic logic [c_XLEN-1:0] next_seq_pc(input logic [c_XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040750_ifu_fifo.sv
// ============================================================================
// Module      : ysyx_22040750_ifu_fifo
// Description : 2-entry {pc, inst} FIFO; flush beats push and pop.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040750_ifu_fifo
  import ysyx_22040750_ifu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [63:0] din_i,
  output logic [63:0] dout_o,
  output logic [1:0]  count_o
);

  logic [63:0] mem_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;
  logic        w_do_pop;
  logic        w_do_push;

  assign w_do_pop  = pop_i && (count_q != 2'd0);
  assign w_do_push = push_i && ((count_q != 2'd2) || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_do_push) wr_ptr_q <= ~wr_ptr_q;
      if (w_do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // Storage is only cleared by reset; a flush just rewinds the pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (w_do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22040750_ifu.sv
// ============================================================================
// Module      : ysyx_22040750_ifu
// Description : Instruction fetch unit; one blocking request in flight, 2-entry
//               buffer to decode. Optional perf counters: YSYX_22040750_IFU_PERF_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040750_ifu
  import ysyx_22040750_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        I_clk,
  input  logic        I_rst,
  output logic [31:0] O_cache_pc,
  output logic        O_cache_pc_valid,
  input  logic        I_cache_pc_ready,
  input  logic [31:0] I_cache_inst,
  input  logic        I_cache_inst_valid,
  input  logic        I_redirect_valid,
  input  logic [31:0] I_redirect_pc,
  output logic [31:0] O_inst,
  output logic [31:0] O_inst_pc,
  output logic        O_inst_valid,
  input  logic        I_inst_ready
`ifdef YSYX_22040750_IFU_PERF_EN
  ,
  output logic [63:0] O_perf_fetch_cnt,
  output logic [63:0] O_perf_stall_cnt
`endif
);

  localparam logic [1:0] c_FULL = 2'(BUF_DEPTH);

  logic [1:0]   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         kill_q, kill_d;

  logic [1:0]   w_count;
  logic [1:0]   w_count_next;
  logic         w_accept;
  logic         w_ret;
  logic         w_push;
  logic         w_pop;
  logic [63:0]  w_head_bits;
  fetch_entry_t w_head;

  assign w_accept = (state_q == c_ST_REQ) && I_cache_pc_ready;
  assign w_ret    = (state_q == c_ST_WAIT) && I_cache_inst_valid;
  assign w_push   = w_ret && !kill_q && !I_redirect_valid;
  assign w_pop    = (w_count != 2'd0) && I_inst_ready;

  assign w_count_next = I_redirect_valid ? 2'd0
                      : (w_count + {1'b0, w_push} - {1'b0, w_pop});

  ysyx_22040750_ifu_fifo u_fifo (
    .clk_i   (I_clk),
    .rst_i   (I_rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (I_redirect_valid),
    .din_i   ({req_pc_q, I_cache_inst}),
    .dout_o  (w_head_bits),
    .count_o (w_count)
  );

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= c_ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'd0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;
    case (state_q)
      c_ST_IDLE: begin
        if (I_redirect_valid) begin
          state_d  = c_ST_REQ;
          req_pc_d = I_redirect_pc;
          pc_d     = I_redirect_pc;
        end else if (w_count < c_FULL) begin
          state_d  = c_ST_REQ;
          req_pc_d = pc_q;
        end
      end
      c_ST_REQ: begin
        // A pending kill means pc already holds a redirect target; keep it.
        if (w_accept) begin
          state_d = c_ST_WAIT;
          if (I_redirect_valid) begin
            kill_d = 1'b1;
            pc_d   = I_redirect_pc;
          end else if (!kill_q) begin
            pc_d = next_seq_pc(req_pc_q);
          end
        end else if (I_redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = I_redirect_pc;
        end
      end
      c_ST_WAIT: begin
        if (w_ret) begin
          kill_d = 1'b0;
          if (I_redirect_valid) begin
            state_d  = c_ST_REQ;
            req_pc_d = I_redirect_pc;
            pc_d     = I_redirect_pc;
          end else if (w_count_next < c_FULL) begin
            state_d  = c_ST_REQ;
            req_pc_d = pc_q;
          end else begin
            state_d = c_ST_IDLE;
          end
        end else if (I_redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = I_redirect_pc;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    O_cache_pc_valid = (state_q == c_ST_REQ);
  end

  assign O_cache_pc   = req_pc_q;
  assign w_head       = fetch_entry_t'(w_head_bits);
  assign O_inst       = w_head.inst;
  assign O_inst_pc    = w_head.pc;
  assign O_inst_valid = (w_count != 2'd0);

`ifdef YSYX_22040750_IFU_PERF_EN
  logic [63:0] fetch_cnt_q;
  logic [63:0] stall_cnt_q;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      fetch_cnt_q <= 64'd0;
      stall_cnt_q <= 64'd0;
    end else begin
      if (w_push) fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (((state_q == c_ST_REQ) || (state_q == c_ST_WAIT)) && (w_count == 2'd0))
        stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign O_perf_fetch_cnt = fetch_cnt_q;
  assign O_perf_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040750_ifu.sv
// ============================================================================
// Module      : tb_ysyx_22040750_ifu
// Description : Self-checking bench: transaction-level fetch/buffer model plus
//               directed scenarios and randomized traffic.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040750_ifu;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [31:0] O_cache_pc;
  logic        O_cache_pc_valid;
  logic        I_cache_pc_ready;
  logic [31:0] I_cache_inst;
  logic        I_cache_inst_valid;
  logic        I_redirect_valid;
  logic [31:0] I_redirect_pc;
  logic [31:0] O_inst;
  logic [31:0] O_inst_pc;
  logic        O_inst_valid;
  logic        I_inst_ready;
`ifdef YSYX_22040750_IFU_PERF_EN
  logic [63:0] O_perf_fetch_cnt;
  logic [63:0] O_perf_stall_cnt;
`endif

  always #5 I_clk = ~I_clk;

  ysyx_22040750_ifu dut (
    .I_clk              (I_clk),
    .I_rst              (I_rst),
    .O_cache_pc         (O_cache_pc),
    .O_cache_pc_valid   (O_cache_pc_valid),
    .I_cache_pc_ready   (I_cache_pc_ready),
    .I_cache_inst       (I_cache_inst),
    .I_cache_inst_valid (I_cache_inst_valid),
    .I_redirect_valid   (I_redirect_valid),
    .I_redirect_pc      (I_redirect_pc),
    .O_inst             (O_inst),
    .O_inst_pc          (O_inst_pc),
    .O_inst_valid       (O_inst_valid),
    .I_inst_ready       (I_inst_ready)
`ifdef YSYX_22040750_IFU_PERF_EN
    ,
    .O_perf_fetch_cnt   (O_perf_fetch_cnt),
    .O_perf_stall_cnt   (O_perf_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Model state: expected buffer contents, next expected fetch/delivery pcs,
  // and the one request the cache is holding.
  ent_t        mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] fetch_exp, deliver_exp, out_pc, prev_pc;
  bit          outstanding, out_killed, stale, prev_hold;
  int          wait_left, lat_cfg, idle_run;
  logic [63:0] m_fetch, m_stall;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle_checks();
    chk1("inst_valid", O_inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk32("inst_pc", O_inst_pc, mq[0].pc);
      chk32("inst_data", O_inst, mq[0].inst);
    end
    if (prev_hold) begin
      chk1("req_held_valid", O_cache_pc_valid, 1'b1);
      chk32("req_held_pc", O_cache_pc, prev_pc);
    end
    if (outstanding) chk1("one_in_flight", O_cache_pc_valid, 1'b0);
    if (!outstanding && !O_cache_pc_valid && mq.size() < 2) idle_run++;
    else idle_run = 0;
    chk1("fetch_liveness", idle_run > 1, 1'b0);
`ifdef YSYX_22040750_IFU_PERF_EN
    chk64("perf_fetch", O_perf_fetch_cnt, m_fetch);
    chk64("perf_stall", O_perf_stall_cnt, m_stall);
`endif
  endtask

  task automatic do_reset();
    I_rst = 1'b1;
    I_cache_pc_ready = 1'b0;
    I_cache_inst = 32'd0;
    I_cache_inst_valid = 1'b0;
    I_redirect_valid = 1'b0;
    I_redirect_pc = 32'd0;
    I_inst_ready = 1'b0;
    repeat (3) @(posedge I_clk);
    @(negedge I_clk);
    mq.delete();
    outstanding = 0; out_killed = 0; stale = 0; prev_hold = 0;
    wait_left = 0; idle_run = 0;
    fetch_exp = 32'h8000_0000; deliver_exp = 32'h8000_0000;
    m_fetch = 64'd0; m_stall = 64'd0;
    chk1("rst_req_valid", O_cache_pc_valid, 1'b0);
    chk1("rst_inst_valid", O_inst_valid, 1'b0);
    chk32("rst_cache_pc", O_cache_pc, 32'd0);
    chk32("rst_inst", O_inst, 32'd0);
    chk32("rst_inst_pc", O_inst_pc, 32'd0);
`ifdef YSYX_22040750_IFU_PERF_EN
    chk64("rst_perf_fetch", O_perf_fetch_cnt, 64'd0);
    chk64("rst_perf_stall", O_perf_stall_cnt, 64'd0);
`endif
    I_rst = 1'b0;
  endtask

  // Drive one cycle at a negedge, advance the model across the coming posedge,
  // then check at the following negedge.
  task automatic step(input bit rdy, input bit ird, input bit redir, input logic [31:0] rpc);
    bit acc, ret, stray, pop;
    acc   = O_cache_pc_valid && rdy;
    ret   = outstanding && (wait_left == 0);
    stray = !outstanding && !O_cache_pc_valid && ($urandom_range(0, 3) == 0);
    pop   = (mq.size() != 0) && ird;
    I_cache_pc_ready   = rdy;
    I_inst_ready       = ird;
    I_redirect_valid   = redir;
    I_redirect_pc      = rpc;
    I_cache_inst_valid = ret || stray;
    I_cache_inst       = ret ? inst_of(out_pc) : $urandom;
    prev_hold = O_cache_pc_valid && !rdy;
    prev_pc   = O_cache_pc;

    if ((O_cache_pc_valid || outstanding) && mq.size() == 0) m_stall++;

    if (redir) begin
      mq.delete();
    end else if (pop) begin
      chk32("deliver_order", O_inst_pc, deliver_exp);
      deliver_exp = O_inst_pc + 32'd4;
      pop_log.push_back(O_inst_pc);
      void'(mq.pop_front());
    end

    if (ret) begin
      outstanding = 0;
      if (!out_killed && !redir) begin
        mq.push_back('{pc: out_pc, inst: inst_of(out_pc)});
        m_fetch++;
      end
    end else if (outstanding) begin
      wait_left--;
    end

    if (acc) begin
      acc_log.push_back(O_cache_pc);
      chk1("room_at_accept", mq.size() < 2, 1'b1);
      if (stale) begin
        out_killed = 1;
        stale = 0;
      end else begin
        chk32("fetch_pc", O_cache_pc, fetch_exp);
        fetch_exp  = fetch_exp + 32'd4;
        out_killed = 0;
      end
      outstanding = 1;
      out_pc      = O_cache_pc;
      wait_left   = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 2));
    end

    if (redir) begin
      fetch_exp   = rpc;
      deliver_exp = rpc;
      stale       = O_cache_pc_valid && !rdy;
      if (outstanding) out_killed = 1;
    end

    @(posedge I_clk);
    @(negedge I_clk);
    cycle_checks();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, pidx;
    logic [31:0] rpc;
    lat_cfg = 0;
    do_reset();

    // Sequential fetch from reset.
    step(1, 1, 0, 32'd0);
    chk1("first_req_valid", O_cache_pc_valid, 1'b1);
    chk32("first_req_pc", O_cache_pc, 32'h8000_0000);

    // Decode stalled: buffer fills to two, fetch stops.
    repeat (10) step(1, 0, 0, 32'd0);
    chk1("full_no_req", O_cache_pc_valid, 1'b0);
    chk1("full_valid", O_inst_valid, 1'b1);
    chk32("full_head_pc", O_inst_pc, 32'h8000_0000);
    step(1, 1, 0, 32'd0);
    step(1, 0, 0, 32'd0);
    chk1("resume_valid", O_cache_pc_valid, 1'b1);
    chk32("resume_pc", O_cache_pc, 32'h8000_0008);
    repeat (6) step(1, 1, 0, 32'd0);
    chk32("seq_pop0", pop_log[0], 32'h8000_0000);
    chk32("seq_pop1", pop_log[1], 32'h8000_0004);
    chk32("seq_pop2", pop_log[2], 32'h8000_0008);

    // Redirect while waiting on a slow return.
    lat_cfg = 2;
    for (int i = 0; i < 10 && !O_cache_pc_valid; i++) step(0, 0, 0, 32'd0);
    chk1("t3_in_req", O_cache_pc_valid, 1'b1);
    step(1, 0, 0, 32'd0);
    idx = acc_log.size();
    step(1, 1, 1, 32'h8000_1000);
    chk1("t3_flushed", O_inst_valid, 1'b0);
    repeat (8) step(1, 0, 0, 32'd0);
    chk32("t3_target", (acc_log.size() > idx) ? acc_log[idx] : 32'hxxxx_xxxx, 32'h8000_1000);

    // Redirect while a request is held unaccepted.
    lat_cfg = 0;
    for (int i = 0; i < 10 && !O_cache_pc_valid; i++) step(0, 1, 0, 32'd0);
    chk1("t4_in_req", O_cache_pc_valid, 1'b1);
    idx = acc_log.size();
    step(0, 1, 1, 32'h8000_2000);
    repeat (3) step(0, 1, 0, 32'd0);
    repeat (6) step(1, 1, 0, 32'd0);
    chk32("t4_target", (acc_log.size() > idx + 1) ? acc_log[idx + 1] : 32'hxxxx_xxxx,
          32'h8000_2000);

    // Redirect coinciding with a return and a pop, then wrap past 2^32.
    repeat (6) step(1, 0, 0, 32'd0);
    step(0, 1, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    step(1, 0, 0, 32'd0);
    chk1("t5_pre_nonempty", O_inst_valid, 1'b1);
    idx  = acc_log.size();
    pidx = pop_log.size();
    step(1, 1, 1, 32'hFFFF_FFFC);
    chk1("t5_flushed", O_inst_valid, 1'b0);
    repeat (8) step(1, 1, 0, 32'd0);
    chk32("t5_target", (acc_log.size() > idx) ? acc_log[idx] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
    chk32("t6_pop_top", (pop_log.size() > pidx) ? pop_log[pidx] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
    chk32("t6_pop_wrap", (pop_log.size() > pidx + 1) ? pop_log[pidx + 1] : 32'hxxxx_xxxx,
          32'h0000_0000);

    // Randomized traffic with a reset in the middle.
    lat_cfg = -1;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFFC;
        1:       rpc = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
        2:       rpc = $urandom;
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 14) == 0, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
